instr_decode_stage: RTL and testbench

Parametrised, registered instruction-decode stage for the 9-bit CPU family. It generalises the fixed opcode/register field split to configurable widths. It adds sequential behaviour the flat encoding lacks:
- fusing a `lith`/`litl` pair into one wide immediate;
- stalling for memory-op latency;
- a sticky halt on `func dne`.

It sits between instruction fetch and the execute/register-file stage, with valid/ready handshakes on both sides.

---
 rtl/instr_decode_stage_if.sv | 30 +++
 rtl/instr_decode_stage.sv | 128 ++++++++++++
 tb/tb_instr_decode_stage.sv | 127 ++++++++++++
 3 files changed

// File: rtl/instr_decode_stage_if.sv
// instr_decode_stage_if: fetch-side and execute-side handshake bundle of the decode stage
// master: environment (drives in_valid/instr/out_ready); slave: decode stage (drives in_ready and the record)
interface instr_decode_stage_if #(
  parameter int OPW  = 5,
  parameter int RW   = 4,
  parameter int IW   = OPW + RW,
  parameter int IMMW = 2 * RW
);
  logic            in_valid;
  logic            in_ready;
  logic [IW-1:0]   instr;
  logic            out_valid;
  logic            out_ready;
  logic [OPW-1:0]  op;
  logic [RW-1:0]   rsel;
  logic [IMMW-1:0] imm;
  logic            imm_valid;
  logic            is_mem;
  logic            is_branch;
  logic            is_func;
  logic            halted;
  modport master (
    output in_valid, instr, out_ready,
    input  in_ready, out_valid, op, rsel, imm, imm_valid, is_mem, is_branch, is_func, halted
  );
  modport slave (
    input  in_valid, instr, out_ready,
    output in_ready, out_valid, op, rsel, imm, imm_valid, is_mem, is_branch, is_func, halted
  );
endinterface

// File: rtl/instr_decode_stage.sv
// instr_decode_stage: registered decode with lith/litl fusion, memory-latency stall and sticky halt
// ports: clk, reset (sync, active-high), bus (slave side of instr_decode_stage_if)
module instr_decode_stage #(
  parameter int OPW     = 5,
  parameter int RW      = 4,
  parameter int IW      = OPW + RW,
  parameter int IMMW    = 2 * RW,
  parameter int MEM_LAT = 2
) (
  input logic                 clk,
  input logic                 reset,
  instr_decode_stage_if.slave bus
);
  localparam logic [OPW-1:0] LITL = OPW'(0);
  localparam logic [OPW-1:0] LITH = OPW'(1);
  typedef enum logic [2:0] {IDLE, HI_PEND, FLUSH_HI, MEM_WAIT, HALT} state_t;
  typedef struct packed {
    logic [OPW-1:0]  op;
    logic [RW-1:0]   rsel;
    logic [IMMW-1:0] imm;
    logic            immv;
    logic            mem;
    logic            br;
    logic            fn;
  } rec_t;
  function automatic rec_t dec(input logic [IW-1:0] i);
    rec_t r;
    r.op   = i[IW-1:RW];
    r.rsel = i[RW-1:0];
    r.immv = r.op == LITL;
    r.imm  = r.immv ? IMMW'(r.rsel) : '0;
    r.mem  = r.op == OPW'(16) || r.op == OPW'(17);
    r.br   = r.op == OPW'(15) || (r.op >= OPW'(20) && r.op <= OPW'(23));
    r.fn   = r.op == OPW'(31);
    return r;
  endfunction
  function automatic state_t next_of(input rec_t r);
    return r.mem ? MEM_WAIT : (r.fn && (&r.rsel)) ? HALT : IDLE;
  endfunction
  state_t          state_q, state_d;
  logic            ov_q, ov_d;
  rec_t            rec_q, rec_d;
  logic [RW-1:0]   hi_q, hi_d;
  logic [IW-1:0]   hold_q, hold_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            in_ready, in_fire, out_fire;
  rec_t            in_rec, hold_rec, lith_rec, fuse_rec;
  assign in_rec   = dec(bus.instr);
  assign hold_rec = dec(hold_q);
  assign lith_rec = '{op: LITH, rsel: hi_q, imm: IMMW'({hi_q, {RW{1'b0}}}), immv: 1'b1, default: '0};
  assign fuse_rec = '{op: LITL, rsel: bus.instr[RW-1:0], imm: IMMW'({hi_q, bus.instr[RW-1:0]}), immv: 1'b1, default: '0};
  assign in_ready = !reset && (state_q == IDLE || state_q == HI_PEND) && (!ov_q || bus.out_ready);
  assign in_fire  = bus.in_valid && in_ready;
  assign out_fire = ov_q && bus.out_ready;
  always_comb begin
    state_d = state_q;
    ov_d    = ov_q && !bus.out_ready;
    rec_d   = rec_q;
    hi_d    = hi_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (in_fire) begin
        if (in_rec.op == LITH) begin
          hi_d    = in_rec.rsel;
          state_d = HI_PEND;
        end else begin
          ov_d    = 1'b1;
          rec_d   = in_rec;
          state_d = next_of(in_rec);
        end
      end
      HI_PEND: if (in_fire) begin
        if (in_rec.op == LITH) hi_d = in_rec.rsel;
        else begin
          ov_d    = 1'b1;
          rec_d   = in_rec.op == LITL ? fuse_rec : lith_rec;
          hold_d  = in_rec.op == LITL ? hold_q : bus.instr;
          hi_d    = '0;
          state_d = in_rec.op == LITL ? IDLE : FLUSH_HI;
        end
      end
      FLUSH_HI: if (out_fire) begin
        ov_d    = 1'b1;
        rec_d   = hold_rec;
        hold_d  = '0;
        state_d = next_of(hold_rec);
      end
      // the counter starts only once the memory record itself has been taken
      MEM_WAIT: if (ov_q) begin
        cnt_d   = bus.out_ready ? 4'(MEM_LAT) : cnt_q;
        state_d = (bus.out_ready && MEM_LAT == 0) ? IDLE : MEM_WAIT;
      end else begin
        cnt_d   = cnt_q - 4'd1;
        state_d = cnt_q <= 4'd1 ? IDLE : MEM_WAIT;
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ov_q    <= 1'b0;
      rec_q   <= '0;
      hi_q    <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ov_q    <= ov_d;
      rec_q   <= rec_d;
      hi_q    <= hi_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
    end
  end
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = ov_q;
  assign bus.op        = rec_q.op;
  assign bus.rsel      = rec_q.rsel;
  assign bus.imm       = rec_q.imm;
  assign bus.imm_valid = rec_q.immv;
  assign bus.is_mem    = rec_q.mem;
  assign bus.is_branch = rec_q.br;
  assign bus.is_func   = rec_q.fn;
  assign bus.halted    = state_q == HALT;
endmodule

// File: tb/tb_instr_decode_stage.sv
// tb_instr_decode_stage: directed-vector check of instr_decode_stage with default parameters
module tb_instr_decode_stage;
  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;
  instr_decode_stage_if b ();
  instr_decode_stage dut (.clk(clk), .reset(reset), .bus(b));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic r, input logic v, input logic [8:0] ins, input logic rdy);
    @(negedge clk);
    reset      = r;
    b.in_valid = v;
    b.instr    = ins;
    b.out_ready = rdy;
    #1;
  endtask
  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b1;
    b.in_valid = 1'b0;
    b.instr = '0;
    b.out_ready = 1'b1;
    cyc(1, 0, 9'h000, 1);
    chk("rst_in_ready", b.in_ready, 0);
    chk("rst_out_valid", b.out_valid, 0);
    chk("rst_halted", b.halted, 0);
    chk("rst_imm", b.imm, 0);
    cyc(0, 0, 9'h000, 1);
    chk("rel_in_ready", b.in_ready, 1);
    chk("rel_out_valid", b.out_valid, 0);
    cyc(0, 1, 9'h01A, 1);
    cyc(0, 1, 9'h003, 1);
    chk("lith_no_out", b.out_valid, 0);
    chk("hipend_ready", b.in_ready, 1);
    cyc(0, 0, 9'h000, 1);
    chk("fuse_valid", b.out_valid, 1);
    chk("fuse_op", b.op, 0);
    chk("fuse_imm", b.imm, 8'hA3);
    chk("fuse_immv", b.imm_valid, 1);
    cyc(0, 1, 9'h015, 1);
    chk("fuse_once", b.out_valid, 0);
    cyc(0, 1, 9'h126, 1);
    chk("hipend2_ready", b.in_ready, 1);
    cyc(0, 0, 9'h000, 1);
    chk("flush_valid", b.out_valid, 1);
    chk("flush_op", b.op, 1);
    chk("flush_imm", b.imm, 8'h50);
    chk("flush_immv", b.imm_valid, 1);
    chk("flush_ready", b.in_ready, 0);
    cyc(0, 0, 9'h000, 1);
    chk("held_valid", b.out_valid, 1);
    chk("held_op", b.op, 5'h12);
    chk("held_rsel", b.rsel, 6);
    chk("held_immv", b.imm_valid, 0);
    cyc(0, 1, 9'h10A, 1);
    chk("held_once", b.out_valid, 0);
    cyc(0, 0, 9'h000, 1);
    chk("load_valid", b.out_valid, 1);
    chk("load_is_mem", b.is_mem, 1);
    chk("load_rsel", b.rsel, 4'hA);
    cyc(0, 0, 9'h000, 1);
    chk("memwait1_ready", b.in_ready, 0);
    cyc(0, 0, 9'h000, 1);
    chk("memwait2_ready", b.in_ready, 0);
    cyc(0, 1, 9'h170, 1);
    chk("memwait_done", b.in_ready, 1);
    cyc(0, 1, 9'h122, 0);
    chk("bnzr_valid", b.out_valid, 1);
    chk("bnzr_branch", b.is_branch, 1);
    chk("bnzr_not_mem", b.is_mem, 0);
    chk("bp_ready", b.in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 9'h122, 0);
      chk("bp_valid", b.out_valid, 1);
      chk("bp_op", b.op, 5'h17);
      chk("bp_in_ready", b.in_ready, 0);
    end
    cyc(0, 1, 9'h122, 1);
    chk("bp_release_ready", b.in_ready, 1);
    cyc(0, 0, 9'h000, 1);
    chk("after_bp_valid", b.out_valid, 1);
    chk("after_bp_op", b.op, 5'h12);
    chk("after_bp_rsel", b.rsel, 2);
    cyc(0, 1, 9'h10A, 1);
    chk("after_bp_once", b.out_valid, 0);
    cyc(0, 0, 9'h000, 1);
    chk("load2_is_mem", b.is_mem, 1);
    cyc(1, 0, 9'h000, 1);
    chk("memrst_ready_low", b.in_ready, 0);
    cyc(0, 0, 9'h000, 1);
    chk("memrst_ready", b.in_ready, 1);
    chk("memrst_valid", b.out_valid, 0);
    cyc(0, 1, 9'h01F, 1);
    cyc(1, 0, 9'h000, 1);
    cyc(0, 1, 9'h001, 1);
    chk("hirst_ready", b.in_ready, 1);
    cyc(0, 0, 9'h000, 1);
    chk("litl_valid", b.out_valid, 1);
    chk("litl_imm", b.imm, 8'h01);
    chk("litl_immv", b.imm_valid, 1);
    cyc(0, 1, 9'h1FF, 1);
    chk("pre_halt_valid", b.out_valid, 0);
    cyc(0, 1, 9'h126, 1);
    chk("dne_valid", b.out_valid, 1);
    chk("dne_is_func", b.is_func, 1);
    chk("dne_halted", b.halted, 1);
    chk("dne_ready", b.in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 9'h126, 1);
      chk("halt_sticky", b.halted, 1);
      chk("halt_ready", b.in_ready, 0);
      chk("halt_drained", b.out_valid, 0);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
